mux_arb_n: RTL and testbench



---
 rtl/mux_arb_n.sv | 97 +++++++++
 tb/tb_mux_arb_n.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N-channel valid/ready combiner.
// Supports fixed-select and round-robin arbitration.
`default_nettype none

module mux_arb_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] i_in_data,
  input  logic [N-1:0]       i_in_valid,
  output logic [N-1:0]       o_in_ready,
  input  logic               i_mode,
  input  logic [SELW-1:0]    i_sel,
  output logic [WIDTH-1:0]   o_out_data,
  output logic [SELW-1:0]    o_out_ch,
  output logic               o_out_valid,
  input  logic               i_out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_ld;
  logic             w_gnt;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  int               w_best;
  int               w_dist;

  assign w_ld = !r_valid || i_out_ready;

  // RR: the valid channel at the smallest distance after r_ptr wins;
  // r_ptr itself is distance N, so it is considered last.
  always_comb begin
    w_gnt      = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    w_best     = N + 1;
    w_dist     = 0;
    if (!i_mode) begin
      for (int k = 0; k < N; k++) begin
        if ((int'(i_sel) == k) && i_in_valid[k]) begin
          w_gnt      = 1'b1;
          w_gnt_idx  = SELW'(k);
          w_gnt_data = i_in_data[k*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        w_dist = k - int'(r_ptr);
        if (w_dist <= 0) w_dist = w_dist + N;
        if (i_in_valid[k] && (w_dist < w_best)) begin
          w_best     = w_dist;
          w_gnt      = 1'b1;
          w_gnt_idx  = SELW'(k);
          w_gnt_data = i_in_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Gated by rst_n so no handshake completes while reset is held.
  always_comb begin
    o_in_ready = '0;
    for (int k = 0; k < N; k++) begin
      o_in_ready[k] = rst_n && w_ld && w_gnt && (w_gnt_idx == SELW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= SELW'(N - 1);
    end else if (w_ld) begin
      r_valid <= w_gnt;
      if (w_gnt) begin
        r_data <= w_gnt_data;
        r_ch   <= w_gnt_idx;
        r_ptr  <= w_gnt_idx;
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_ch    = r_ch;
  assign o_out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed self-checking bench for mux_arb_n (N=4, SELW=3).
`default_nettype none

module tb_mux_arb_n;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 3;

  logic               clk;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_valid;
  logic               out_ready;

  int checks   = 0;
  int failures = 0;

  mux_arb_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_mode      (mode),
    .i_sel       (sel),
    .o_out_data  (out_data),
    .o_out_ch    (out_ch),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_inready got=%b exp=0000", in_ready); end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
    step();
    checks++; if (out_ch !== 3'd0 || out_valid !== 1'b1 || out_data !== 8'hA0) begin failures++; $display("FAIL reset_first_word got ch=%0d v=%b d=%h exp ch=0 v=1 d=a0", out_ch, out_valid, out_data); end
    step();
    checks++; if (out_ch !== 3'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL reset_second_word got ch=%0d v=%b exp ch=1 v=1", out_ch, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin failures++; $display("FAIL reset_midstream got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid, out_data, out_ch); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (out_ch !== 3'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL reset_rr_restart got ch=%0d v=%b exp ch=0 v=1", out_ch, out_valid); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 3'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_inready got=%b exp=0100", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_data !== 8'hA2 || out_ch !== 3'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL fixed_word%0d got d=%h ch=%0d v=%b exp d=a2 ch=2 v=1", i, out_data, out_ch, out_valid); end
      checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_inready%0d got=%b exp=0100", i, in_ready); end
    end
    sel = 3'd5;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL fixed_sel5_inready got=%b exp=0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'hA2 || out_ch !== 3'd2) begin failures++; $display("FAIL fixed_sel5_out got v=%b d=%h ch=%0d exp v=0 d=a2 ch=2", out_valid, out_data, out_ch); end
  endtask

  task automatic test_rr();
    logic [2:0] exp_ch [4];
    exp_ch[0] = 3'd1; exp_ch[1] = 3'd3; exp_ch[2] = 3'd1; exp_ch[3] = 3'd3;
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (out_ch !== 3'(i % 4) || out_data !== 8'(8'hA0 + (i % 4)) || out_valid !== 1'b1) begin failures++; $display("FAIL rr_all%0d got ch=%0d d=%h v=%b exp ch=%0d", i, out_ch, out_data, out_valid, i % 4); end
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_ch !== exp_ch[i] || out_valid !== 1'b1) begin failures++; $display("FAIL rr_13_%0d got ch=%0d v=%b exp ch=%0d", i, out_ch, out_valid, exp_ch[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_inready got=%b exp=0000", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_ch !== 3'd0 || out_data !== 8'hA0 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold%0d got ch=%0d d=%h v=%b rdy=%b exp ch=0 d=a0 v=1 rdy=0000", i, out_ch, out_data, out_valid, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_inready got=%b exp=0010", in_ready); end
    step();
    checks++; if (out_ch !== 3'd1 || out_data !== 8'hA1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_nobubble got ch=%0d d=%h v=%b exp ch=1 d=a1 v=1", out_ch, out_data, out_valid); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    step();
    checks++; if (out_ch !== 3'd1) begin failures++; $display("FAIL ms_rr1 got ch=%0d exp=1", out_ch); end
    mode = 1'b0; sel = 3'd3;
    step();
    checks++; if (out_ch !== 3'd3 || out_data !== 8'hA3) begin failures++; $display("FAIL ms_fixed got ch=%0d d=%h exp ch=3 d=a3", out_ch, out_data); end
    mode = 1'b1;
    step();
    checks++; if (out_ch !== 3'd0 || out_data !== 8'hA0) begin failures++; $display("FAIL ms_rr_resume got ch=%0d d=%h exp ch=0 d=a0", out_ch, out_data); end
  endtask

  task automatic test_idle_gap();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    in_valid = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_data !== 8'hA0) begin failures++; $display("FAIL idle%0d got v=%b d=%h exp v=0 d=a0", i, out_valid, out_data); end
    end
    in_valid = 4'b0100;
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL idle_inready got=%b exp=0100", in_ready); end
    step();
    checks++; if (out_ch !== 3'd2 || out_data !== 8'hA2 || out_valid !== 1'b1) begin failures++; $display("FAIL idle_resume got ch=%0d d=%h v=%b exp ch=2 d=a2 v=1", out_ch, out_data, out_valid); end
  endtask

  initial begin
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_mode_switch();
    test_idle_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
